// File: rtl/llc_access_arbiter_pkg.sv
// Shared types for the LLC access arbiter: cache op codes, arbiter FSM states,
// default address width and the op-legality helper.
package llc_pkg;

  localparam int LLC_ADDR_W = 32;

  typedef enum logic [1:0] {
    LLC_OP_READ  = 2'b00,
    LLC_OP_WRITE = 2'b01
  } llc_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  function automatic logic llc_op_legal(input logic [1:0] op);
    return (op == LLC_OP_READ) || (op == LLC_OP_WRITE);
  endfunction

endpackage

// File: rtl/llc_access_arbiter_rr_pick.sv
// Combinational rotating-priority picker: lowest requester at or above i_ptr
// wins, wrapping to the lowest requester overall when none sits above it.
module llc_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_vld
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  always_comb begin
    w_mask = '0;
    for (int j = 0; j < N; j++) w_mask[j] = (j >= int'(i_ptr));
  end

  assign w_hi  = i_req & w_mask;
  assign w_sel = (|w_hi) ? w_hi : i_req;
  // isolate the lowest set bit
  assign o_gnt = w_sel & (~w_sel + N'(1));
  assign o_vld = |i_req;

endmodule

// File: rtl/llc_access_arbiter.sv
// Round-robin arbiter/sequencer for the single LLC lookup port.
// Optional LLC_ARB_SNOOP_PRIO_EN: requester 0 (snoop) gets fixed absolute priority.
module llc_access_arbiter
  import llc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = LLC_ADDR_W,
  parameter int LOOKUP_LAT = 1,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cache_valid,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic [1:0]                cache_op,
  input  logic                      cache_hit,
  input  logic                      cache_miss,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_hit,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

  arb_state_t          r_state, w_next;
  logic [ID_W-1:0]     r_ptr, r_id;
  logic                r_hit, r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_cache_addr;
  logic [1:0]          r_cache_op;

  logic [NUM_REQ-1:0]  w_pick_req, w_pick_gnt, w_grant;
  logic                w_pick_vld, w_any, w_hs, w_legal, w_adv;
  logic [ID_W-1:0]     w_gid, w_ptr_nxt;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [1:0]          w_sel_op;

  llc_rr_pick #(.N(NUM_REQ), .PW(ID_W)) u_pick (
    .i_req (w_pick_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_vld (w_pick_vld)
  );

`ifdef LLC_ARB_SNOOP_PRIO_EN
  assign w_pick_req = {req_valid[NUM_REQ-1:1], 1'b0};
  assign w_grant    = req_valid[0] ? NUM_REQ'(1) : w_pick_gnt;
  assign w_any      = req_valid[0] | w_pick_vld;
  assign w_adv      = (w_gid != '0);
`else
  assign w_pick_req = req_valid;
  assign w_grant    = w_pick_gnt;
  assign w_any      = w_pick_vld;
  assign w_adv      = 1'b1;
`endif

  always_comb begin
    w_gid      = '0;
    w_sel_addr = '0;
    w_sel_op   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_gid      = ID_W'(j);
        w_sel_addr = req_addr[j*ADDR_W +: ADDR_W];
        w_sel_op   = req_op[j*2 +: 2];
      end
    end
  end

  assign w_hs      = (r_state == IDLE) && w_any;
  assign w_legal   = llc_op_legal(w_sel_op);
  assign w_ptr_nxt = (w_gid == ID_W'(NUM_REQ-1)) ? '0 : w_gid + ID_W'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = w_legal ? ISSUE : RESP;
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Rotation advances at grant time so an illegal op still gives up its turn.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_hit        <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_cache_addr <= '0;
      r_cache_op   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_id  <= w_gid;
          r_hit <= 1'b0;
          r_err <= ~w_legal;
          if (w_legal) begin
            r_cache_addr <= w_sel_addr;
            r_cache_op   <= w_sel_op;
          end
          if (w_adv) r_ptr <= w_ptr_nxt;
        end
        ISSUE: r_cnt <= CNT_W'(LOOKUP_LAT - 1);
        WAIT: begin
          if (r_cnt == '0) begin
            r_hit <= cache_hit & ~cache_miss;
            r_err <= ~(cache_hit ^ cache_miss);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready   = (r_state == IDLE) ? w_grant : '0;
    cache_valid = (r_state == ISSUE);
    rsp_valid   = (r_state == RESP);
    rsp_id      = (r_state == RESP) ? r_id  : '0;
    rsp_hit     = (r_state == RESP) ? r_hit : 1'b0;
    rsp_err     = (r_state == RESP) ? r_err : 1'b0;
    busy        = (r_state != IDLE);
  end

  assign cache_addr = r_cache_addr;
  assign cache_op   = r_cache_op;

endmodule

// File: tb/tb_llc_access_arbiter.sv
// Scoreboard bench for llc_access_arbiter: a cycle-level reference model queues
// expected grants/issues/responses; a negedge monitor compares what the DUT shows.
module tb_llc_access_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int LAT  = 2;
  localparam int IDW  = 2;
  localparam int MAXC = 4000;

  logic            clk, reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_op;
  logic            cache_valid, cache_hit, cache_miss;
  logic [AW-1:0]   cache_addr;
  logic [1:0]      cache_op;
  logic            rsp_valid, rsp_hit, rsp_err, busy;
  logic [IDW-1:0]  rsp_id;

  llc_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LOOKUP_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op), .req_ready(req_ready),
    .cache_valid(cache_valid), .cache_addr(cache_addr), .cache_op(cache_op),
    .cache_hit(cache_hit), .cache_miss(cache_miss),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cyc; int id; } g_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [1:0] op; } i_t;
  typedef struct { int cyc; int id; bit hit; bit err; } r_t;

  g_t gq[$];
  i_t iq[$];
  r_t rq[$];

  int errors = 0, checks = 0;
  int cyc = 0, next_free = 0, last_hs = -10, ptr = 0;
  bit exp_busy = 1'b0;
  bit pv[N];
  logic [AW-1:0] pa[N];
  logic [1:0]    po[N];
  bit hit_a[MAXC], miss_a[MAXC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick();
    int w = -1;
`ifdef LLC_ARB_SNOOP_PRIO_EN
    if (pv[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int idx = (ptr + k) % N;
      if (w < 0 && idx != 0 && pv[idx]) w = idx;
    end
`else
    for (int k = 0; k < N; k++) begin
      int idx = (ptr + k) % N;
      if (w < 0 && pv[idx]) w = idx;
    end
`endif
    return w;
  endfunction

  // Reference: one transaction at a time, fixed latency, fair rotation.
  task automatic model(input bit rst);
    int w, s;
    exp_busy = (cyc > last_hs) && (cyc < next_free);
    if (rst) begin
      while (gq.size() > 0 && gq[$].cyc > cyc) void'(gq.pop_back());
      while (iq.size() > 0 && iq[$].cyc > cyc) void'(iq.pop_back());
      while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
      ptr = 0; next_free = cyc + 1; last_hs = cyc;
      return;
    end
    if (cyc < next_free) return;
    w = pick();
    if (w < 0) return;
    last_hs = cyc;
    gq.push_back('{cyc, w});
    if (po[w] < 2) begin
      iq.push_back('{cyc + 1, pa[w], po[w]});
      s = cyc + 1 + LAT;
      rq.push_back('{cyc + 2 + LAT, w, hit_a[s] && !miss_a[s], hit_a[s] == miss_a[s]});
      next_free = cyc + 3 + LAT;
    end else begin
      rq.push_back('{cyc + 1, w, 1'b0, 1'b1});
      next_free = cyc + 2;
    end
`ifdef LLC_ARB_SNOOP_PRIO_EN
    if (w != 0) ptr = (w + 1) % N;
`else
    ptr = (w + 1) % N;
`endif
    pv[w] = 1'b0;
  endtask

  task automatic step(input bit rst);
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = rst ? 1'b0 : pv[i];
      req_addr[i*AW +: AW] = pa[i];
      req_op[i*2 +: 2]     = po[i];
    end
    cache_hit  = hit_a[cyc];
    cache_miss = miss_a[cyc];
    model(rst);
  endtask

  task automatic wait_grant(input int id);
    int k = 0;
    while (pv[id] && k < 80) begin step(1'b0); k++; end
    if (pv[id]) begin
      checks++; errors++;
      $display("FAIL grant_timeout id=%0d actual=pending required=granted", id);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cyc + 1 < next_free && k < 40) begin step(1'b0); k++; end
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    chk({name, "_req_ready"},   req_ready,   0);
    chk({name, "_cache_valid"}, cache_valid, 0);
    chk({name, "_cache_addr"},  cache_addr,  0);
    chk({name, "_cache_op"},    cache_op,    0);
    chk({name, "_rsp_valid"},   rsp_valid,   0);
    chk({name, "_rsp_id"},      rsp_id,      0);
    chk({name, "_rsp_hit"},     rsp_hit,     0);
    chk({name, "_rsp_err"},     rsp_err,     0);
    chk({name, "_busy"},        busy,        0);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [1:0] o);
    pv[i] = 1'b1; pa[i] = a; po[i] = o;
  endtask

  // Monitor: every cycle, compare DUT strobes against the front of each queue.
  logic [N-1:0] m_er;
  bit m_ecv, m_erv;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      m_er = (gq.size() > 0 && gq[0].cyc == cyc) ? N'(1) << gq[0].id : '0;
      if (m_er != 0 || req_ready != 0) begin
        chk("req_ready", req_ready, m_er);
        if (m_er != 0) void'(gq.pop_front());
      end
      m_ecv = (iq.size() > 0 && iq[0].cyc == cyc);
      if (m_ecv || cache_valid) begin
        chk("cache_valid", cache_valid, m_ecv);
        if (m_ecv) begin
          chk("cache_addr", cache_addr, iq[0].addr);
          chk("cache_op", cache_op, iq[0].op);
          void'(iq.pop_front());
        end
      end
      m_erv = (rq.size() > 0 && rq[0].cyc == cyc);
      if (m_erv || rsp_valid) begin
        chk("rsp_valid", rsp_valid, m_erv);
        if (m_erv) begin
          chk("rsp_id", rsp_id, rq[0].id);
          chk("rsp_hit", rsp_hit, rq[0].hit);
          chk("rsp_err", rsp_err, rq[0].err);
          void'(rq.pop_front());
        end
      end
      chk("busy", busy, exp_busy);
    end
  end

  initial begin
    int n0;
    reset = 1'b1; req_valid = '0; req_addr = '0; req_op = '0;
    cache_hit = 1'b0; cache_miss = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        hit_a[c] = 1'($urandom); miss_a[c] = hit_a[c];
      end else begin
        hit_a[c] = 1'($urandom); miss_a[c] = !hit_a[c];
      end
    end
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pa[i] = '0; po[i] = '0; end

    repeat (3) step(1'b1);
    step(1'b0);
    check_zero("reset");

    // single read from requester 1
    set_req(1, 32'h1234_5640, 2'b00);
    wait_grant(1);
    wait_idle();

    // all four held valid for 8 grants, from a reset pointer
    step(1'b1);
    step(1'b0);
    n0 = 0;
    for (int k = 0; k < 8 * (LAT + 3) + 4; k++) begin
      for (int i = 0; i < N; i++) if (!pv[i]) set_req(i, $urandom, 2'($urandom_range(0, 1)));
      step(1'b0);
    end
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    wait_idle();

    // pointer wrap: grant 3 alone, then 0 and 3 together
    set_req(3, 32'hCAFE_0003, 2'b01);
    wait_grant(3);
    wait_idle();
    step(1'b0);
    set_req(0, 32'hCAFE_0000, 2'b00);
    set_req(3, 32'hCAFE_1003, 2'b00);
    wait_grant(0);
    wait_grant(3);
    wait_idle();

    // protocol errors: hit and miss both set, then illegal ops
    for (int c = cyc; c < cyc + 40; c++) begin hit_a[c] = 1'b1; miss_a[c] = 1'b1; end
    set_req(2, 32'h0000_2222, 2'b00);
    wait_grant(2);
    wait_idle();
    set_req(1, 32'h0000_1111, 2'b11);
    wait_grant(1);
    wait_idle();
    set_req(3, 32'h0000_3333, 2'b10);
    wait_grant(3);
    wait_idle();

    // reset in the first WAIT cycle drops the in-flight request
    set_req(2, 32'hDEAD_BEEF, 2'b00);
    wait_grant(2);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    check_zero("rst_wait");
    set_req(0, 32'h0000_A000, 2'b01);
    set_req(2, 32'h0000_A002, 2'b00);
    wait_grant(0);
    wait_grant(2);
    wait_idle();

    // random traffic with drops, illegal ops and mixed results
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++) begin
        if (pv[i]) begin
          if ($urandom_range(0, 15) == 0) pv[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(i, $urandom, ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3))
                                                            : 2'($urandom_range(0, 1)));
        end
      end
      step(1'b0);
    end
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    wait_idle();
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    #1;
    chk("queues_drained", gq.size() + iq.size() + rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
